// File: rtl/grf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// grf_wr_ctrl
// Write-port controller for the 32x32 general register file. The single GRF
// write port is shared between two requesters:
//   * the pipeline W stage, which has fixed priority and is never held off
//   * the long-latency result port L, which uses a valid/ready handshake and
//     is buffered in a small FIFO
// The block also keeps a scoreboard of registers that have a long-latency
// write outstanding, so the hazard unit can stall readers of them. It raises
// stall_req when a FIFO head has waited too long behind W-stage writes.
//
// Parameters
//   DEPTH       L-request FIFO entries (power of two, >= 2)
//   STARVE_LIM  cycles a FIFO head may wait before stall_req asserts (>= 1)
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   W_RFWr/W_A3/W_WD/W_PC       W-stage write request
//   L_req/L_A3/L_WD/L_PC        long-latency result, accepted when L_ready
//   L_ready                     FIFO can accept (count < DEPTH)
//   I_valid/I_A3                long-latency op issued; marks I_A3 pending
//   RFWr/A3/WD/PC               GRF write port
//   busy                        bit r set: register r has a pending L write
//   stall_req                   FIFO head is starving; hazard unit bubbles W
//   L_ack                       pulse one cycle after a FIFO entry was written
// ---------------------------------------------------------------------------
module grf_wr_ctrl #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_RFWr,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_WD,
    input  logic [31:0] W_PC,
    input  logic        L_req,
    input  logic [4:0]  L_A3,
    input  logic [31:0] L_WD,
    input  logic [31:0] L_PC,
    output logic        L_ready,
    input  logic        I_valid,
    input  logic [4:0]  I_A3,
    output logic        RFWr,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC,
    output logic [31:0] busy,
    output logic        stall_req,
    output logic        L_ack
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned AW = $clog2(STARVE_LIM + 1);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [AW-1:0] LIM_C   = AW'(STARVE_LIM);

    // FIFO storage; pointers wrap naturally because DEPTH is a power of two.
    logic [4:0]  fifo_a3 [DEPTH];
    logic [31:0] fifo_wd [DEPTH];
    logic [31:0] fifo_pc [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic [AW-1:0] age;
    logic [31:0]   busy_nxt;

    logic w_use;
    logic fifo_nonempty;
    logic push;
    logic pop;

    logic [4:0]  head_a3;
    logic [31:0] head_wd;
    logic [31:0] head_pc;

    assign head_a3 = fifo_a3[rd_ptr];
    assign head_wd = fifo_wd[rd_ptr];
    assign head_pc = fifo_pc[rd_ptr];

    assign fifo_nonempty = (count != '0);
    assign L_ready       = (count < DEPTH_C);

    // A W write to $0 is no write at all, so the FIFO may use the port.
    assign w_use = W_RFWr && (W_A3 != '0);
    assign pop   = !w_use && fifo_nonempty;

    // L results aimed at $0 are acknowledged by the handshake but never stored.
    assign push  = L_req && L_ready && (L_A3 != '0);

    assign stall_req = (age >= LIM_C) && fifo_nonempty;

    // ---------------------------------------------------------------------
    // Write-port selection
    // ---------------------------------------------------------------------
    always_comb begin
        RFWr = 1'b0;
        A3   = '0;
        WD   = '0;
        PC   = '0;
        if (w_use) begin
            RFWr = 1'b1;
            A3   = W_A3;
            WD   = W_WD;
            PC   = W_PC;
        end else if (fifo_nonempty) begin
            RFWr = 1'b1;
            A3   = head_a3;
            WD   = head_wd;
            PC   = head_pc;
        end
    end

    // ---------------------------------------------------------------------
    // Scoreboard next state: clear for the drained entry first, then the
    // issue-side set, so a same-cycle set on the same register wins.
    // ---------------------------------------------------------------------
    always_comb begin
        busy_nxt = busy;
        if (pop) begin
            busy_nxt[head_a3] = 1'b0;
        end
        if (I_valid && (I_A3 != '0)) begin
            busy_nxt[I_A3] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // ---------------------------------------------------------------------
    // FIFO data storage (contents need no reset; validity is in count)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a3[wr_ptr] <= L_A3;
            fifo_wd[wr_ptr] <= L_WD;
            fifo_pc[wr_ptr] <= L_PC;
        end
    end

    // ---------------------------------------------------------------------
    // Pointers, count, scoreboard, starvation age, acknowledge
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
            age    <= '0;
            L_ack  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            busy  <= busy_nxt;
            L_ack <= pop;

            // Age tracks how long the current head has been passed over.
            if (pop || !fifo_nonempty) begin
                age <= '0;
            end else if (age < LIM_C) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grf_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grf_wr_ctrl
// Scoreboard bench for grf_wr_ctrl. The stimulus process drives one cycle
// of inputs, asks a queue-based reference model what the write port, L_ready,
// busy, stall_req and L_ack must show during that cycle, and pushes that
// expectation. A separate monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_grf_wr_ctrl;

    localparam int unsigned DEPTH      = 2;
    localparam int unsigned STARVE_LIM = 4;

    logic        clk;
    logic        reset;
    logic        W_RFWr;
    logic [4:0]  W_A3;
    logic [31:0] W_WD;
    logic [31:0] W_PC;
    logic        L_req;
    logic [4:0]  L_A3;
    logic [31:0] L_WD;
    logic [31:0] L_PC;
    logic        L_ready;
    logic        I_valid;
    logic [4:0]  I_A3;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC;
    logic [31:0] busy;
    logic        stall_req;
    logic        L_ack;

    grf_wr_ctrl #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .W_RFWr    (W_RFWr),
        .W_A3      (W_A3),
        .W_WD      (W_WD),
        .W_PC      (W_PC),
        .L_req     (L_req),
        .L_A3      (L_A3),
        .L_WD      (L_WD),
        .L_PC      (L_PC),
        .L_ready   (L_ready),
        .I_valid   (I_valid),
        .I_A3      (I_A3),
        .RFWr      (RFWr),
        .A3        (A3),
        .WD        (WD),
        .PC        (PC),
        .busy      (busy),
        .stall_req (stall_req),
        .L_ack     (L_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic        rfwr;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        l_ready;
        logic [31:0] busy;
        logic        stall;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: pending L entries in order, pending-register
    // set, cycles the current head has waited, and last cycle's drain flag.
    ent_t     mq[$];
    bit [31:0] m_busy;
    int        m_age;
    bit        m_ack;

    int errors = 0;
    int checks = 0;

    function automatic bit m_stall();
        return (m_age >= int'(STARVE_LIM)) && (mq.size() > 0);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_busy = '0;
        m_age  = 0;
        m_ack  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle that has an expectation is compared field by field.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("RFWr",      {31'd0, RFWr},      {31'd0, e.rfwr});
            chk("L_ready",   {31'd0, L_ready},   {31'd0, e.l_ready});
            chk("stall_req", {31'd0, stall_req}, {31'd0, e.stall});
            chk("L_ack",     {31'd0, L_ack},     {31'd0, e.ack});
            chk("busy",      busy,               e.busy);
            if (e.rfwr) begin
                chk("A3", {27'd0, A3}, {27'd0, e.a3});
                chk("WD", WD, e.wd);
                chk("PC", PC, e.pc);
            end else begin
                chk("idle_port", {A3, WD[26:0]} | WD | PC, 32'd0);
            end
        end
    end

    // One cycle: drive inputs now (just after a rising edge), record what the
    // port must show before the next edge, advance the model across that edge.
    task automatic cyc(input bit w, input logic [4:0] wa3, input logic [31:0] wwd,
                       input logic [31:0] wpc, input bit lr, input logic [4:0] la3,
                       input logic [31:0] lwd, input logic [31:0] lpc,
                       input bit iv, input logic [4:0] ia3);
        exp_t e;
        ent_t ne;
        bit   w_writes;
        bit   drained;
        bit   was_empty;
        W_RFWr = w;   W_A3 = wa3; W_WD = wwd; W_PC = wpc;
        L_req  = lr;  L_A3 = la3; L_WD = lwd; L_PC = lpc;
        I_valid = iv; I_A3 = ia3;

        w_writes  = w && (wa3 != 0);
        was_empty = (mq.size() == 0);
        e.rfwr    = 1'b0;
        e.a3      = '0;
        e.wd      = '0;
        e.pc      = '0;
        if (w_writes) begin
            e.rfwr = 1'b1; e.a3 = wa3; e.wd = wwd; e.pc = wpc;
        end else if (!was_empty) begin
            e.rfwr = 1'b1; e.a3 = mq[0].a3; e.wd = mq[0].wd; e.pc = mq[0].pc;
        end
        e.l_ready = (mq.size() < int'(DEPTH));
        e.busy    = m_busy;
        e.stall   = m_stall();
        e.ack     = m_ack;
        exp_q.push_back(e);

        drained = !w_writes && !was_empty;
        if (drained) begin
            m_busy[mq[0].a3] = 1'b0;
            void'(mq.pop_front());
        end
        if (lr && e.l_ready && la3 != 0) begin
            ne.a3 = la3; ne.wd = lwd; ne.pc = lpc;
            mq.push_back(ne);
        end
        if (iv && ia3 != 0) m_busy[ia3] = 1'b1;
        m_busy[0] = 1'b0;
        if (drained || was_empty) m_age = 0;
        else if (m_age < int'(STARVE_LIM)) m_age++;
        m_ack = drained;

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        W_RFWr = 0; W_A3 = 0; W_WD = 0; W_PC = 0;
        L_req = 0; L_A3 = 0; L_WD = 0; L_PC = 0;
        I_valid = 0; I_A3 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        int guard;
        model_clear();
        do_reset();

        // Reset state.
        idle(2);

        // W priority over a queued L result, then L drains and acks.
        cyc(1, 5, 32'h11, 32'h100, 1, 7, 32'h22, 32'h200, 0, 0);
        cyc(1, 5, 32'h11, 32'h104, 0, 0, 0, 0, 0, 0);
        cyc(1, 5, 32'h11, 32'h108, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Starvation: W keeps writing until the head has waited long enough.
        cyc(1, 3, 32'h33, 32'h300, 1, 8, 32'h44, 32'h400, 0, 0);
        guard = 0;
        while (!m_stall() && guard < 20) begin
            cyc(1, 3, 32'h33, 32'h304, 0, 0, 0, 0, 0, 0);
            guard++;
        end
        cyc(1, 3, 32'h33, 32'h308, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // FIFO full, rejected request, then pop+push at count=1.
        cyc(1, 4, 32'h55, 32'h500, 1, 10, 32'hA, 32'h600, 0, 0);
        cyc(1, 4, 32'h55, 32'h504, 1, 11, 32'hB, 32'h604, 0, 0);
        cyc(1, 4, 32'h55, 32'h508, 1, 12, 32'hDEAD, 32'h608, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 13, 32'hC, 32'h60C, 0, 0);
        idle(3);

        // Scoreboard set/clear and set-wins-over-clear.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        cyc(1, 2, 32'h66, 32'h700, 1, 9, 32'h99, 32'h704, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        cyc(1, 2, 32'h66, 32'h708, 1, 9, 32'h98, 32'h70C, 1, 9);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        idle(2);

        // $0 handling on all three inputs.
        cyc(1, 2, 32'h77, 32'h800, 1, 14, 32'hE, 32'h804, 0, 0);
        cyc(1, 0, 32'hBAD, 32'h808, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'hF00, 32'h80C, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        // Reset with entries in flight discards them.
        cyc(1, 6, 32'h1, 32'h900, 1, 15, 32'h2, 32'h904, 1, 15);
        cyc(1, 6, 32'h1, 32'h904, 1, 16, 32'h3, 32'h908, 0, 0);
        do_reset();
        idle(3);

        // Randomized traffic; the bench plays the hazard unit and usually
        // bubbles W when the model predicts a stall.
        for (int n = 0; n < 3000; n++) begin
            bit          w;
            int unsigned wden;
            wden = (n / 500) % 3;
            w = ($urandom_range(0, 9) < (wden == 0 ? 3 : (wden == 1 ? 7 : 9)));
            if (m_stall() && $urandom_range(0, 3) != 0) w = 1'b0;
            cyc(w, 5'($urandom_range(0, 31)), $urandom, $urandom,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom, $urandom,
                ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
        idle(DEPTH + STARVE_LIM + 4);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending expectations required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grf_wr_ctrl.md
# grf_wr_ctrl

Write-port controller for the 32×32 general register file. The GRF has one write port. This block shares it between two requesters:

- **Pipeline W stage:** fixed priority, no backpressure.
- **Long-latency result port (L):** valid/ready handshake, buffered in a small FIFO.

It also keeps a scoreboard of registers with an outstanding long-latency write, so the hazard unit can stall readers. It sits between the W stage, the long-latency unit and the GRF write inputs.

## Interface
Parameters:
- DEPTH, 2, L-request FIFO entries (power of two, ≥2)
- STARVE_LIM, 4, cycles a FIFO head may wait before `stall_req` asserts (≥1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- W_RFWr  in  1  W-stage write enable
- W_A3  in  5  W-stage destination register
- W_WD  in  32  W-stage write data
- W_PC  in  32  W-stage instruction PC
- L_req  in  1  long-latency result valid
- L_A3  in  5  long-latency destination register
- L_WD  in  32  long-latency write data
- L_PC  in  32  PC of the producing instruction
- L_ready  out  1  FIFO can accept; 1 when count < DEPTH
- I_valid  in  1  long-latency op issued this cycle (marks destination pending)
- I_A3  in  5  destination of the issued op
- RFWr  out  1  to GRF write enable
- A3  out  5  to GRF write address
- WD  out  32  to GRF write data
- PC  out  32  to GRF PC
- busy  out  32  scoreboard; bit r = register r has a pending L write; bit 0 always 0
- stall_req  out  1  request to hazard unit to bubble W
- L_ack  out  1  registered pulse: a FIFO entry was written to the GRF last cycle

## Operation
**Port selection.** Combinational, evaluated every cycle.
- W uses the port when W_RFWr=1 and W_A3≠0. Then RFWr=1 and A3/WD/PC = W_A3/W_WD/W_PC.
- Otherwise, if the FIFO is non-empty, the FIFO head drives A3/WD/PC with RFWr=1, and the head is popped at the posedge.
- Otherwise RFWr=0 and A3/WD/PC=0.
- A W write to $0 counts as an idle port, so the FIFO may drain that cycle.

**FIFO.**
- Push on L_req && L_ready.
- Push and pop in the same cycle are allowed when count < DEPTH. Count is then unchanged.
- There is no same-cycle bypass: a pushed entry is written to the GRF no earlier than the next cycle.
- L requests with L_A3=0 are accepted and dropped. They are not pushed and cause no write.

**Scoreboard.**
- On I_valid with I_A3≠0, set busy[I_A3].
- When a FIFO entry is written to the GRF, clear busy[entry A3].
- Set and clear of the same register in the same cycle: set wins.
- W writes never change busy.

**Starvation.**
- `age` counts consecutive cycles the FIFO is non-empty and the head is not written. It saturates at STARVE_LIM and resets to 0 on every pop and whenever the FIFO is empty.
- stall_req = (age ≥ STARVE_LIM) && FIFO non-empty.
- The hazard unit answers stall_req by inserting a bubble, so W_RFWr=0. The head then drains next cycle.
- Arbitration is not changed by stall_req: W still wins if it writes.

**Reset.** Synchronous, on posedge with reset=1:
- FIFO emptied and pointers cleared.
- busy=0, age=0, L_ack=0.
- Combinational outputs then read RFWr=0, A3=0, WD=0, PC=0, L_ready=1, stall_req=0, unless W drives the port.
- Entries in flight at reset are discarded. No write to the GRF occurs for them.

## Timing
- W path: zero latency. Outputs follow W_* combinationally and the GRF writes at the same posedge.
- L path: minimum 1 cycle from accepted L_req to RFWr=1. Worst case is bounded by STARVE_LIM plus hazard-unit reaction plus FIFO position.
- L_ready is combinational from the registered count only; it never depends on L_req.
- L_ack is high exactly one cycle after each cycle in which a FIFO head was written.
- busy updates are visible the cycle after I_valid or the write.

## Test plan
1. **Reset state.** Reset for 2 cycles → RFWr=0, L_ready=1, busy=0, stall_req=0, L_ack=0.
2. **W priority.** W writes $5=0x11 every cycle while an L request for $7=0x22 is accepted → GRF receives only W writes. After W_RFWr falls, $7=0x22 is written next cycle and L_ack pulses.
3. **Starvation.** Continuous W writes with one queued L entry → stall_req rises after exactly 4 waiting cycles. The bench drops W_RFWr → L entry written, stall_req and age return to 0.
4. **FIFO full.** Push 2 L entries while W is busy → L_ready=0. With pop and push in the same cycle at count=1, count stays 1 and ordering is preserved (0xA then 0xB written in order).
5. **Scoreboard.** I_valid $9 → busy[9]=1. L write to $9 drains → busy[9]=0. I_valid $9 in the same cycle that an entry for $9 drains → busy[9] stays 1.
6. **$0 handling.** W_A3=0 with W_RFWr=1 and a FIFO entry pending → FIFO entry written that cycle. L_A3=0 request → accepted, no write, no L_ack. I_A3=0 → busy unchanged.
